// File: rtl/common_types_pkg.sv
// Shared types and constants for the controller-side arbitration logic.
package common_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // Arbiter FSM state; kept as plain constants for legacy tool flows.
    typedef logic [0:0] arb_state_t;
    localparam arb_state_t IDLE = 1'b0;
    localparam arb_state_t BUSY = 1'b1;

    // Write size encodings on the controller handshake.
    localparam logic [1:0] WSIZE_NONE = 2'b00;
    localparam logic [1:0] WSIZE_WORD = 2'b11;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first requester after last_ptr, circularly.
module rr_picker #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] last_ptr,
    output logic             valid,
    output logic [PTR_W-1:0] idx
);

    logic [PTR_W-1:0] cand;

    // Scan last_ptr+1 .. last_ptr+NREQ (mod NREQ); last_ptr itself comes last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = PTR_W'((32'(last_ptr) + k) % NREQ);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/axi_controller_arbiter.sv
// Round-robin sharing of one axi_controller request port between NREQ requesters.
// One transaction at a time; the grant is held until ready&done, then IDLE for a cycle.
module axi_controller_arbiter
    import common_types_pkg::*;
#(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        s_read,
    input  logic [2*NREQ-1:0]      s_write,
    input  logic [NREQ*ADDR_W-1:0] s_addr,
    input  logic [NREQ*DATA_W-1:0] s_store,
    input  logic [NREQ-1:0]        s_done,
    output logic [NREQ-1:0]        s_ready,
    output logic [NREQ*DATA_W-1:0] s_load,
    output logic                   m_read,
    output logic [1:0]             m_write,
    output logic [ADDR_W-1:0]      m_addr,
    output logic [DATA_W-1:0]      m_store,
    output logic                   m_done,
    input  logic                   m_ready,
    input  logic [DATA_W-1:0]      m_load,
    output logic [NREQ-1:0]        grant,
    output logic                   busy
);

    localparam int unsigned PTR_W = $clog2(NREQ);

    arb_state_t       state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [PTR_W-1:0] last_ptr_q, last_ptr_d;
    logic             orphan_q, orphan_d;

    logic [NREQ-1:0]  req;
    logic             pick_valid;
    logic [PTR_W-1:0] pick_idx;
    logic [31:0]      sel;
    logic             owner_req;
    logic             orphan_c;

    // A requester is active when reading or issuing a non-empty write.
    always_comb begin
        req = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            req[i] = s_read[i] | (s_write[2*i +: 2] != WSIZE_NONE);
        end
    end

    rr_picker #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req      (req),
        .last_ptr (last_ptr_q),
        .valid    (pick_valid),
        .idx      (pick_idx)
    );

    // last_ptr holds the owner for the whole BUSY phase.
    assign sel = 32'(last_ptr_q);

    // Grant mux: owner's request to the controller, controller response to the owner only.
    always_comb begin
        m_read    = 1'b0;
        m_write   = WSIZE_NONE;
        m_addr    = '0;
        m_store   = '0;
        m_done    = 1'b0;
        s_ready   = '0;
        s_load    = '0;
        owner_req = 1'b0;
        orphan_c  = 1'b0;
        if (state_q == BUSY) begin
            m_read    = s_read[last_ptr_q];
            m_write   = s_write[2*sel +: 2];
            m_addr    = s_addr[ADDR_W*sel +: ADDR_W];
            m_store   = s_store[DATA_W*sel +: DATA_W];
            owner_req = s_read[last_ptr_q] | (s_write[2*sel +: 2] != WSIZE_NONE);
            // An owner that abandoned its request gets its done supplied on the next ready.
            orphan_c  = orphan_q | ~owner_req;
            m_done    = s_done[last_ptr_q] | (orphan_c & m_ready);
            s_ready[last_ptr_q]          = m_ready;
            s_load[DATA_W*sel +: DATA_W] = m_load;
        end
    end

    // Next-state: grant on any request in IDLE, release on ready&done in BUSY.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_ptr_d = last_ptr_q;
        orphan_d   = orphan_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d    = BUSY;
                    grant_d    = NREQ'(1) << pick_idx;
                    last_ptr_d = pick_idx;
                    orphan_d   = 1'b0;
                end
            end
            BUSY: begin
                if (m_ready && m_done) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    orphan_d = 1'b0;
                end else if (!owner_req) begin
                    orphan_d = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                grant_d  = '0;
                orphan_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            last_ptr_q <= PTR_W'(NREQ - 1);
            orphan_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_ptr_q <= last_ptr_d;
            orphan_q   <= orphan_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q == BUSY);

endmodule
